nibble_step_counter: RTL and testbench

//  Sequential source for the 4-bit value V consumed by the binary-to-two-digit decimal display stage.

---
 rtl/nibble_step_counter_pkg.sv | 23 ++
 rtl/nibble_step_counter_key_debouncer.sv | 51 +++++
 rtl/nibble_step_counter.sv | 76 +++++++
 tb/tb_nibble_step_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_step_counter_pkg.sv
// Shared definitions for the nibble step counter slice.
//   mode_t          : FSM state encoding, which is also the MODE LED value
//   *_DEF           : default debounce / prescale constants for a 50 MHz clock
//   step4 / wraps4  : modulo-16 step and wrap detection for a single advance
package nibble_step_counter_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  localparam int DEB_CYCLES_DEF = 500000;    // 10 ms @ 50 MHz
  localparam int TICK_DIV_DEF   = 50000000;  // 1 Hz  @ 50 MHz

  function automatic logic [3:0] step4(input logic [3:0] v, input logic up);
    return up ? v + 4'd1 : v - 4'd1;
  endfunction

  function automatic logic wraps4(input logic [3:0] v, input logic up);
    return up ? (v == 4'hF) : (v == 4'h0);
  endfunction

endpackage

// File: rtl/nibble_step_counter_key_debouncer.sv
// key_debouncer: turns a raw, active-low, asynchronous pushbutton into a
// one-cycle press pulse.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   key_n  : raw pushbutton, low = pressed
//   press  : one-cycle pulse when the debounced level falls 1->0
// The key goes through two flops first. A candidate change must then be seen
// for DEB_CYCLES consecutive synced samples before the debounced level moves.
module key_debouncer
  import nibble_step_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int              CW      = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1, sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the current level cancels a pending change.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;  // only the falling edge (press) is an event
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nibble_step_counter.sv
// nibble_step_counter: 4-bit count source for the two-digit decimal display.
//   CLOCK_50 : system clock
//   RESET    : asynchronous active-high reset
//   KEY_STEP : raw active-low step button (asynchronous)
//   SW_LOAD  : load value; LOAD : level, forces V to SW_LOAD while high
//   UP       : 1 = increment, 0 = decrement
//   RUN      : 1 = auto-advance once per prescaler tick, 0 = advance per press
//   V        : registered count
//   WRAP     : one-cycle pulse on the advance that wraps 15->0 or 0->15
//   MODE     : registered FSM state (0 manual, 1 auto)
module nibble_step_counter
  import nibble_step_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF   // must be >= 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_STEP,
  input  logic [3:0] SW_LOAD,
  input  logic       LOAD,
  input  logic       UP,
  input  logic       RUN,
  output logic [3:0] V,
  output logic       WRAP,
  output logic       MODE
);

  localparam int            PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  mode_t         state;
  logic [PW-1:0] ps;
  logic          press;
  logic          tick;

  assign MODE = state;
  assign tick = (state == MODE_AUTO) && (ps == PS_MAX);

  key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .key_n (KEY_STEP),
    .press (press)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= MODE_MANUAL;
    else       state <= RUN ? MODE_AUTO : MODE_MANUAL;
  end

  // Held at zero outside AUTO and during LOAD so the first tick always lands
  // a full TICK_DIV cycles after entering AUTO or dropping LOAD.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                                 ps <= '0;
    else if (state == MODE_MANUAL || LOAD)     ps <= '0;
    else if (ps == PS_MAX)                     ps <= '0;
    else                                       ps <= ps + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      V    <= 4'd0;
      WRAP <= 1'b0;
    end else if (LOAD) begin
      V    <= SW_LOAD;
      WRAP <= 1'b0;
    end else if ((state == MODE_MANUAL && press) || (state == MODE_AUTO && tick)) begin
      V    <= step4(V, UP);
      WRAP <= wraps4(V, UP);
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_step_counter.sv
module tb_nibble_step_counter;

  localparam int DEB = 4;
  localparam int TD  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b1;
  logic [3:0] sw  = 4'd0;
  logic       load = 1'b0;
  logic       up   = 1'b1;
  logic       run  = 1'b0;
  logic [3:0] v;
  logic       wrap;
  logic       mode;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers, one update per clock).
  int m_v, m_wrap, m_mode, m_ps;
  int m_k1, m_k2, m_deb, m_stable, m_press;

  always #5 clk = ~clk;

  nibble_step_counter #(.DEB_CYCLES(DEB), .TICK_DIV(TD)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .KEY_STEP (key),
    .SW_LOAD  (sw),
    .LOAD     (load),
    .UP       (up),
    .RUN      (run),
    .V        (v),
    .WRAP     (wrap),
    .MODE     (mode)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_wrap = 0; m_mode = 0; m_ps = 0;
    m_k1 = 1; m_k2 = 1; m_deb = 1; m_stable = 0; m_press = 0;
  endtask

  // One clock of the reference: all "next" values derive from pre-edge state.
  task automatic model_step();
    bit advance;
    advance = (m_mode == 0 && m_press == 1) || (m_mode == 1 && m_ps == TD - 1);
    m_wrap = 0;
    if (load) m_v = sw;
    else if (advance) begin
      m_wrap = up ? (m_v == 15) : (m_v == 0);
      m_v    = (m_v + (up ? 1 : 15)) % 16;
    end
    m_ps = (m_mode == 0 || load) ? 0 : (m_ps + 1) % TD;
    // Debounced level follows the synced key only after DEB agreeing samples.
    m_press = 0;
    if (m_k2 != m_deb) begin
      m_stable++;
      if (m_stable == DEB) begin
        m_deb = m_k2; m_stable = 0; m_press = (m_k2 == 0);
      end
    end else m_stable = 0;
    m_k2 = m_k1;
    m_k1 = key;
    m_mode = run;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      chk("V", v, 4'(m_v));
      chk("WRAP", {3'b0, wrap}, 4'(m_wrap));
      chk("MODE", {3'b0, mode}, 4'(m_mode));
    end
  endtask

  // Assert reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_V", v, 4'd0);
    chk("rst_WRAP", {3'b0, wrap}, 4'd0);
    chk("rst_MODE", {3'b0, mode}, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic press_key();
    key = 1'b0; cyc(10);
    key = 1'b1; cyc(10);
  endtask

  initial begin
    int hold;
    int guard;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2);
    chk("reset_state", v, 4'd0);

    // Debounce: short glitch ignored, long press steps once, release silent.
    key = 1'b0; cyc(3);
    key = 1'b1; cyc(10);
    chk("glitch_ignored", v, 4'd0);
    key = 1'b0; cyc(10);
    chk("press_step", v, 4'd1);
    key = 1'b1; cyc(10);
    chk("release_silent", v, 4'd1);

    // Wrap both directions.
    load = 1'b1; sw = 4'd15; cyc(1);
    load = 1'b0; up = 1'b1; press_key();
    chk("wrap_up", v, 4'd0);
    up = 1'b0; key = 1'b0;
    guard = 0;
    while (v != 4'd15 && guard < 20) begin cyc(1); guard++; end
    chk("wrap_dn_v", v, 4'd15);
    chk("wrap_dn_pulse", {3'b0, wrap}, 4'd1);
    key = 1'b1; cyc(10);

    // Async reset with a nonzero count.
    do_reset();
    cyc(1);

    // Auto mode from 3: first advance 8 cycles after MODE rises.
    load = 1'b1; sw = 4'd3; up = 1'b1; cyc(1);
    load = 1'b0; run = 1'b1; cyc(1);
    chk("auto_mode", {3'b0, mode}, 4'd1);
    cyc(7);
    chk("auto_before", v, 4'd3);
    cyc(1);
    chk("auto_first", v, 4'd4);
    key = 1'b0; cyc(8);
    chk("auto_second", v, 4'd5);
    key = 1'b1; cyc(16);
    chk("auto_press_ignored", v, 4'd7);

    // LOAD dominates ticks and presses; tick restarts after LOAD drops.
    load = 1'b1; sw = 4'd9;
    key = 1'b0; cyc(10); key = 1'b1; cyc(10);
    chk("load_hold", v, 4'd9);
    load = 1'b0; cyc(7);
    chk("load_no_tick", v, 4'd9);
    cyc(1);
    chk("load_first_tick", v, 4'd10);

    // Reset while prescaler is at 5, then full period after re-entering AUTO.
    guard = 0;
    while (m_ps != 5 && guard < 20) begin cyc(1); guard++; end
    chk("reached_ps5", 4'(m_ps), 4'd5);
    do_reset();
    cyc(1);
    chk("midrst_mode", {3'b0, mode}, 4'd1);
    cyc(7);
    chk("midrst_before", v, 4'd0);
    cyc(1);
    chk("midrst_adv", v, 4'd1);
    run = 1'b0; cyc(2);

    // Randomised traffic against the model.
    hold = 0;
    for (int i = 0; i < 700; i++) begin
      if (hold == 0) begin
        key  = ~key;
        hold = $urandom_range(1, 12);
      end
      hold--;
      load = ($urandom_range(0, 15) == 0);
      sw   = 4'($urandom);
      up   = 1'($urandom);
      if ($urandom_range(0, 47) == 0) run = ~run;
      if ($urandom_range(0, 249) == 0) do_reset();
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
